// File: rtl/ram_access_sequencer_if.sv
// Handshake bundle between the memory control stage, the RAM access sequencer
// and the synchronous data RAM.
interface ram_access_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  ram_rw_flag;
  logic [ADDR_WIDTH-1:0] address_in;
  logic [DATA_WIDTH-1:0] wdata_in;
  logic [DATA_WIDTH-1:0] rdata_out;
  logic                  done;
  logic                  err;
  logic                  busy;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Sequencer side.
  modport slave (
    input  req, ram_rw_flag, address_in, wdata_in, mem_rdata,
    output rdata_out, done, err, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Upstream stage together with the RAM.
  modport master (
    output req, ram_rw_flag, address_in, wdata_in, mem_rdata,
    input  rdata_out, done, err, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_access_sequencer.sv
// Sequences one RAM access per request with configurable wait states; requests
// at or above ADDR_LIMIT are rejected with err instead of reaching the RAM.
module ram_access_sequencer #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    WAIT_STATES = 2,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT  = 16'h1000
) (
  input  logic                   clk,
  input  logic                   reset,
  ram_access_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  flag_q, flag_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  en_q, en_d;
  logic                  we_q, we_d;

  // Next-state, holding-register and output decode; outputs follow state_d so they register cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    flag_d  = flag_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.address_in;
          wdata_d = bus.wdata_in;
          flag_d  = bus.ram_rw_flag;
          if (bus.address_in < ADDR_LIMIT) begin
            state_d = ST_ACCESS;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          if (!flag_q) begin
            rdata_d = bus.mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    en_d   = (state_d == ST_ACCESS);
    we_d   = en_d & flag_d;
    done_d = (state_d == ST_DONE);
  end

  // State, counter, holding and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      flag_q  <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      flag_q  <= flag_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      we_q    <= we_d;
    end
  end

  assign bus.rdata_out = rdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Drives two sequencers (2 and 0 wait states) with the same requests and checks
// every cycle against a transaction-level timing model and a reference memory.
`timescale 1ns/1ps
module tb_ram_access_sequencer;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req_s, flag_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s;

  ram_access_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  ram_access_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  logic [DW-1:0] ram0 [256];
  logic [DW-1:0] ram1 [256];
  logic [DW-1:0] ref_mem [256];

  assign bus0.req = req_s;  assign bus0.ram_rw_flag = flag_s;
  assign bus0.address_in = addr_s;  assign bus0.wdata_in = wdata_s;
  assign bus1.req = req_s;  assign bus1.ram_rw_flag = flag_s;
  assign bus1.address_in = addr_s;  assign bus1.wdata_in = wdata_s;
  assign bus0.mem_rdata = ram0[bus0.mem_addr[7:0]];
  assign bus1.mem_rdata = ram1[bus1.mem_addr[7:0]];

  ram_access_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(2),
                         .ADDR_LIMIT(16'h1000))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  ram_access_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0),
                         .ADDR_LIMIT(16'h1000))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'hDEADBEEF;
    return (32'(i) * 32'h00010101) ^ 32'h5A000000;
  endfunction

  // RAM models: preload while reset is held, write on enable+write-enable.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        ram0[i] <= init_word(i);
        ram1[i] <= init_word(i);
      end
    end else begin
      if (bus0.mem_en && bus0.mem_we) ram0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
      if (bus1.mem_en && bus1.mem_we) ram1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    end
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] rexp0, rexp1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Expected outputs k cycles after the request edge for a sequencer with ws wait states.
  task automatic chk_dut(input string p, input int ws, input int k, input bit legal,
                         input bit wr, input logic [15:0] a, input logic [31:0] wd,
                         input logic [31:0] rexp, input logic o_busy, input logic o_en,
                         input logic o_we, input logic o_done, input logic o_err,
                         input logic [31:0] o_rd, input logic [15:0] o_ma,
                         input logic [31:0] o_wd);
    bit e_en, e_we, e_done, e_err, e_busy;
    e_en   = legal && (k <= ws + 1);
    e_we   = e_en && wr;
    e_done = legal ? (k == ws + 2) : (k == 1);
    e_err  = !legal && (k == 1);
    e_busy = legal ? (k <= ws + 2) : (k == 1);
    chk1($sformatf("%s k%0d busy", p, k), o_busy, e_busy);
    chk1($sformatf("%s k%0d mem_en", p, k), o_en, e_en);
    chk1($sformatf("%s k%0d mem_we", p, k), o_we, e_we);
    chk1($sformatf("%s k%0d done", p, k), o_done, e_done);
    chk1($sformatf("%s k%0d err", p, k), o_err, e_err);
    chk($sformatf("%s k%0d rdata_out", p, k), o_rd, rexp);
    if (e_en) begin
      chk($sformatf("%s k%0d mem_addr", p, k), {16'd0, o_ma}, {16'd0, a});
      chk($sformatf("%s k%0d mem_wdata", p, k), o_wd, wd);
    end
  endtask

  task automatic do_txn(input logic [15:0] a, input bit wr, input logic [31:0] wd);
    bit legal;
    legal   = (a < 16'h1000);
    addr_s  = a;
    flag_s  = wr;
    wdata_s = wd;
    req_s   = 1'b1;
    @(posedge clk); #1;
    req_s   = 1'b0;
    addr_s  = 16'($urandom);
    wdata_s = $urandom;
    flag_s  = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 6; k++) begin
      if (legal && !wr && k == 4) rexp0 = ref_mem[a[7:0]];
      if (legal && !wr && k == 2) rexp1 = ref_mem[a[7:0]];
      chk_dut("ws2", 2, k, legal, wr, a, wd, rexp0, bus0.busy, bus0.mem_en, bus0.mem_we,
              bus0.done, bus0.err, bus0.rdata_out, bus0.mem_addr, bus0.mem_wdata);
      chk_dut("ws0", 0, k, legal, wr, a, wd, rexp1, bus1.busy, bus1.mem_en, bus1.mem_we,
              bus1.done, bus1.err, bus1.rdata_out, bus1.mem_addr, bus1.mem_wdata);
      @(posedge clk); #1;
    end
    if (legal && wr) ref_mem[a[7:0]] = wd;
  endtask

  initial begin
    reset = 1'b1; req_s = 1'b0; flag_s = 1'b0; addr_s = '0; wdata_s = '0;
    rexp0 = '0; rexp1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    chk_dut("rst0", 2, 99, 1'b1, 1'b0, 16'd0, 32'd0, 32'd0, bus0.busy, bus0.mem_en,
            bus0.mem_we, bus0.done, bus0.err, bus0.rdata_out, bus0.mem_addr, bus0.mem_wdata);
    chk("rst0 mem_addr", {16'd0, bus0.mem_addr}, 32'd0);
    chk("rst0 mem_wdata", bus0.mem_wdata, 32'd0);
    chk1("rst1 busy", bus1.busy, 1'b0);
    chk1("rst1 mem_en", bus1.mem_en, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed accesses, including both sides of the address limit.
    do_txn(16'h0040, 1'b0, 32'h0);
    do_txn(16'h0010, 1'b1, 32'h12345678);
    do_txn(16'h0010, 1'b0, 32'h0);
    do_txn(16'h1000, 1'b0, 32'h0);
    do_txn(16'h0FFF, 1'b1, 32'hCAFEF00D);
    do_txn(16'h0FFF, 1'b0, 32'h0);
    do_txn(16'hFFFF, 1'b1, 32'h11111111);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 16'($urandom_range(0, 255));
      else if (sel == 7) a = 16'h0FFF;
      else if (sel == 8) a = 16'h1000;
      else               a = 16'($urandom_range(16'h1001, 16'hFFFF));
      do_txn(a, 1'($urandom_range(0, 1)), $urandom);
    end

    // Back-to-back reads with req held high; checked on the 2-wait-state unit.
    addr_s = 16'd1; flag_s = 1'b0; req_s = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 11; k++) begin
      bit e_en, e_done, e_busy;
      e_en   = (k <= 3) || (k >= 6 && k <= 8);
      e_done = (k == 4) || (k == 9);
      e_busy = (k <= 4) || (k >= 6 && k <= 9);
      if (k == 4) rexp0 = ref_mem[1];
      if (k == 9) rexp0 = ref_mem[2];
      chk1($sformatf("b2b k%0d mem_en", k), bus0.mem_en, e_en);
      chk1($sformatf("b2b k%0d done", k), bus0.done, e_done);
      chk1($sformatf("b2b k%0d busy", k), bus0.busy, e_busy);
      chk($sformatf("b2b k%0d rdata_out", k), bus0.rdata_out, rexp0);
      if (e_en) chk($sformatf("b2b k%0d mem_addr", k), {16'd0, bus0.mem_addr},
                    (k <= 3) ? 32'd1 : 32'd2);
      if (k == 4) addr_s = 16'd2;
      if (k == 9) req_s = 1'b0;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset in the second ACCESS cycle aborts the access.
    addr_s = 16'h0040; flag_s = 1'b0; req_s = 1'b1;
    @(posedge clk); #1;
    req_s = 1'b0;
    @(posedge clk); #1;
    chk1("abort pre mem_en", bus0.mem_en, 1'b1);
    reset = 1'b1;
    #1;
    chk1("abort mem_en", bus0.mem_en, 1'b0);
    chk1("abort busy", bus0.busy, 1'b0);
    chk1("abort done", bus0.done, 1'b0);
    chk("abort rdata_out", bus0.rdata_out, 32'd0);
    chk1("abort ws0 busy", bus1.busy, 1'b0);
    chk("abort ws0 rdata_out", bus1.rdata_out, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rexp0 = '0; rexp1 = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk1($sformatf("post-abort k%0d done", k), bus0.done, 1'b0);
      chk1($sformatf("post-abort k%0d busy", k), bus0.busy, 1'b0);
    end
    do_txn(16'h0040, 1'b0, 32'h0);
    do_txn(16'h0033, 1'b1, 32'hA5A5F00F);
    do_txn(16'h0033, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
